// File: rtl/reg_read_pkg.sv
// Shared encodings for the register read port: select codes, write-enable bit
// positions, lane geometry and the lane-to-enable mapping helpers.
package reg_read_pkg;

  localparam int BYTE_W   = 8;
  localparam int WORD_W   = 16;
  localparam int NUM_BYTE = 8;
  localparam int NUM_WORD = 4;
  localparam int WE_W     = 12;
  localparam int ENTRY_W  = WORD_W + 1;

  typedef enum logic [3:0] {
    SEL_AL, SEL_CL, SEL_DL, SEL_BL, SEL_AH, SEL_CH, SEL_DH, SEL_BH,
    SEL_AX, SEL_CX, SEL_DX, SEL_BX, SEL_SP, SEL_BP, SEL_SI, SEL_DI
  } sel_e;

  // Write enables run from AL at the MSB down to DI at bit 0.
  typedef enum int unsigned {
    WE_DI = 0, WE_SI = 1, WE_BP = 2, WE_SP = 3,
    WE_BH = 4, WE_DH = 5, WE_CH = 6, WE_AH = 7,
    WE_BL = 8, WE_DL = 9, WE_CL = 10, WE_AL = 11
  } we_bit_e;

  function automatic int byte_we_bit(input int lane);
    return int'(WE_AL) - lane;
  endfunction

  function automatic int word_we_bit(input int lane);
    return int'(WE_SP) - lane;
  endfunction

endpackage

// File: rtl/reg_read_fifo.sv
// Response queue: DEPTH entries of {DWORD, DOUT}, registered ready derived
// from the occupancy count, head entry presented as valid/ready output.
module reg_read_fifo
  import reg_read_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [ENTRY_W-1:0] push_data,
  output logic               pop_valid,
  input  logic               pop_ready,
  output logic [ENTRY_W-1:0] pop_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rdy_q, rdy_d;
  logic               push_fire, pop_fire;

  assign push_fire  = push_valid && rdy_q;
  assign pop_fire   = pop_valid && pop_ready;
  assign push_ready = rdy_q;
  assign pop_valid  = (count_q != '0);
  // Empty queue shows zero so a reset leaves DOUT/DWORD cleared.
  assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_fire);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_fire);
    count_d  = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    rdy_d    = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/reg_read_port.sv
// Register read port: selects the addressed 8/16-bit register from the RF lanes,
// forwards same-cycle writes, and queues the result for the operand consumer.
module reg_read_port
  import reg_read_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RD,
  input  logic [3:0]  SEL,
  output logic        RD_RDY,
  input  logic [63:0] RF_BYTE,
  input  logic [63:0] RF_WORD,
  input  logic [11:0] WE,
  input  logic [15:0] WDATA,
  output logic [15:0] DOUT,
  output logic        DWORD,
  output logic        DVALID,
  input  logic        DREADY
);

  logic [BYTE_W-1:0]  byte_lane [NUM_BYTE];
  logic [WORD_W-1:0]  word_lane [NUM_WORD];
  logic [WORD_W-1:0]  sel_data;
  logic               sel_word;
  logic [ENTRY_W-1:0] pop_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTE; gi++) begin : g_byte
      logic [BYTE_W-1:0] fwd;
      if (gi < NUM_BYTE / 2) begin : g_lo
        assign fwd = WDATA[7:0];
      end else begin : g_hi
        // A high byte written together with its low partner is a 16-bit write.
        assign fwd = WE[byte_we_bit(gi - 4)] ? WDATA[15:8] : WDATA[7:0];
      end
      assign byte_lane[gi] = (BYPASS_EN && WE[byte_we_bit(gi)]) ? fwd
                                                               : RF_BYTE[gi*BYTE_W +: BYTE_W];
    end

    for (gi = 0; gi < NUM_WORD; gi++) begin : g_word
      assign word_lane[gi] = (BYPASS_EN && WE[word_we_bit(gi)]) ? WDATA
                                                               : RF_WORD[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    sel_word = 1'b0;
    if (SEL < SEL_AX) begin
      sel_data = {8'h00, byte_lane[SEL[2:0]]};
    end else if (SEL < SEL_SP) begin
      sel_data = {byte_lane[{1'b1, SEL[1:0]}], byte_lane[{1'b0, SEL[1:0]}]};
      sel_word = 1'b1;
    end else begin
      sel_data = word_lane[SEL[1:0]];
      sel_word = 1'b1;
    end
  end

  reg_read_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push_valid(RD),
    .push_ready(RD_RDY),
    .push_data ({sel_word, sel_data}),
    .pop_valid (DVALID),
    .pop_ready (DREADY),
    .pop_data  (pop_data)
  );

  assign DWORD = pop_data[ENTRY_W-1];
  assign DOUT  = pop_data[WORD_W-1:0];

endmodule

// File: tb/tb_reg_read_port.sv
// Bench for reg_read_port: a forwarding and a non-forwarding instance share
// stimulus; a negedge monitor checks each response against a queued model result.
module tb_reg_read_port;

  logic        CLK = 1'b0;
  logic        RST_N, RD, DREADY;
  logic [3:0]  SEL;
  logic [63:0] RF_BYTE, RF_WORD;
  logic [11:0] WE;
  logic [15:0] WDATA;

  logic        rd_rdy [2];
  logic [15:0] dout   [2];
  logic        dword  [2];
  logic        dvalid [2];

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];
  logic        prev_stall [2];
  logic [16:0] prev_out   [2];

  always #5 CLK = ~CLK;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      reg_read_port #(
        .DEPTH    (2),
        .BYPASS_EN(gi == 0)
      ) u_dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .RD     (RD),
        .SEL    (SEL),
        .RD_RDY (rd_rdy[gi]),
        .RF_BYTE(RF_BYTE),
        .RF_WORD(RF_WORD),
        .WE     (WE),
        .WDATA  (WDATA),
        .DOUT   (dout[gi]),
        .DWORD  (dword[gi]),
        .DVALID (dvalid[gi]),
        .DREADY (DREADY)
      );
    end
  endgenerate

  // Architectural view: register contents as a reader should see them this cycle.
  function automatic logic [16:0] model(input logic [3:0] sel, input logic [63:0] rfb,
                                        input logic [63:0] rfw, input logic [11:0] we,
                                        input logic [15:0] wd, input bit byp);
    logic [7:0]  r8  [8];
    logic [15:0] r16 [4];
    int s;
    for (int i = 0; i < 8; i++) r8[i] = rfb[i*8 +: 8];
    for (int i = 0; i < 4; i++) r16[i] = rfw[i*16 +: 16];
    if (byp) begin
      for (int i = 0; i < 4; i++) begin
        if (we[11-i]) r8[i] = wd[7:0];
        if (we[7-i])  r8[i+4] = we[11-i] ? wd[15:8] : wd[7:0];
        if (we[3-i])  r16[i] = wd;
      end
    end
    s = int'(sel);
    if (s < 8)       return {1'b0, 8'h00, r8[s]};
    else if (s < 12) return {1'b1, r8[s-4], r8[s-8]};
    else             return {1'b1, r16[s-12]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N !== 1'b1) begin
      exp_q0.delete();
      exp_q1.delete();
      for (int k = 0; k < 2; k++) prev_stall[k] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [16:0] cur, exp;
        cur = {dword[k], dout[k]};
        if (prev_stall[k]) begin
          chk($sformatf("stall_valid%0d", k), 32'(dvalid[k]), 32'd1);
          chk($sformatf("stall_hold%0d", k), 32'(cur), 32'(prev_out[k]));
        end
        if (dvalid[k] && DREADY) begin
          if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp%0d: got %h expected none", k, cur);
          end else begin
            exp = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            $display("dut%0d resp dword=%0b dout=%h (model %h)", k, cur[16], cur[15:0], exp);
            chk($sformatf("resp%0d", k), 32'(cur), 32'(exp));
          end
        end
        prev_stall[k] = dvalid[k] && !DREADY;
        prev_out[k]   = cur;
        if (RD && rd_rdy[k]) begin
          if (k == 0) exp_q0.push_back(model(SEL, RF_BYTE, RF_WORD, WE, WDATA, 1'b1));
          else        exp_q1.push_back(model(SEL, RF_BYTE, RF_WORD, WE, WDATA, 1'b0));
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_rdy) DREADY = 1'($urandom_range(0, 1));
  endtask

  // Holds the request until accepted; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] sel, input logic [11:0] we, input logic [15:0] wd,
                       output int cycles);
    bit acc;
    RD = 1'b1; SEL = sel; WE = we; WDATA = wd;
    cycles = 0;
    acc = 1'b0;
    while (!acc && cycles < 50) begin
      @(negedge CLK);
      acc = (rd_rdy[0] === 1'b1);
      step();
      cycles++;
    end
    if (!acc) chk("issue_timeout", 32'(acc), 32'd1);
    RD = 1'b0; WE = '0;
  endtask

  initial begin
    int cyc, total;
    RST_N = 1'b0; RD = 1'b1; SEL = 4'h0; DREADY = 1'b1;
    RF_BYTE = 64'h0; RF_WORD = 64'h0; WE = '0; WDATA = '0;
    repeat (3) step();
    RST_N = 1'b1; RD = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk("rst_dvalid", 32'(dvalid[k]), 32'd0);
      chk("rst_dout",   32'(dout[k]),   32'd0);
      chk("rst_dword",  32'(dword[k]),  32'd0);
      chk("rst_rdy",    32'(rd_rdy[k]), 32'd1);
    end
    step();

    RF_BYTE = 64'h0000_0000_0000_005A;
    issue(4'h0, 12'h000, 16'h0000, cyc);
    chk("lat_valid", 32'(dvalid[0]), 32'd1);
    chk("lat_dout",  32'(dout[0]),   32'h005A);
    chk("lat_dword", 32'(dword[0]),  32'd0);

    RF_BYTE = 64'h0000_0012_0000_0034;
    issue(4'h8, 12'b1000_1000_0000, 16'hBEEF, cyc);
    chk("ax_byp",   32'(dout[0]),  32'hBEEF);
    chk("ax_word",  32'(dword[0]), 32'd1);
    chk("ax_nobyp", 32'(dout[1]),  32'h1234);

    issue(4'h4, 12'b0000_1000_0000, 16'h00C3, cyc);
    chk("ah_byp",   32'(dout[0]), 32'h00C3);
    chk("ah_nobyp", 32'(dout[1]), 32'h0012);
    step();

    RF_WORD = 64'h0000_3333_2222_1111;
    DREADY = 1'b0;
    issue(4'hC, 12'h000, 16'h0, cyc);
    issue(4'hD, 12'h000, 16'h0, cyc);
    RD = 1'b1; SEL = 4'hE;
    repeat (3) begin
      @(negedge CLK);
      chk("full_rdy",  32'(rd_rdy[0]), 32'd0);
      chk("full_head", 32'(dout[0]),   32'h1111);
      step();
    end
    DREADY = 1'b1;
    issue(4'hE, 12'h000, 16'h0, cyc);
    repeat (4) step();

    DREADY = 1'b0;
    issue(4'hC, 12'h000, 16'h0, cyc);
    issue(4'hD, 12'h000, 16'h0, cyc);
    DREADY = 1'b1;
    total = 0;
    for (int n = 0; n < 20; n++) begin
      RF_WORD = {$urandom, $urandom};
      RF_BYTE = {$urandom, $urandom};
      issue(4'($urandom_range(0, 15)), 12'h000, 16'h0, cyc);
      total += cyc;
    end
    chk("full_throughput", 32'(total), 32'd21);
    repeat (4) step();

    DREADY = 1'b0;
    issue(4'hC, 12'h000, 16'h0, cyc);
    issue(4'h9, 12'h000, 16'h0, cyc);
    RST_N = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_q_dvalid", 32'(dvalid[k]), 32'd0);
      chk("rst_q_dout",   32'(dout[k]),   32'd0);
    end
    RST_N = 1'b1; DREADY = 1'b1;
    repeat (2) begin
      step();
      chk("rst_q_empty", 32'(dvalid[0]), 32'd0);
    end

    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [11:0] we;
      RF_BYTE = {$urandom, $urandom};
      RF_WORD = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       we = '0;
        1:       we = 12'b1000_1000_0000 >> $urandom_range(0, 3);
        default: we = 12'($urandom);
      endcase
      issue(4'($urandom_range(0, 15)), we, 16'($urandom), cyc);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_rdy = 1'b0;
    DREADY = 1'b1;
    cyc = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && cyc < 20) begin
      step();
      cyc++;
    end
    chk("drain_q0", 32'(exp_q0.size()), 32'd0);
    chk("drain_q1", 32'(exp_q1.size()), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_read_port.md
Name: reg_read_port

Overview:
- Read-side counterpart of the register-file write decoder.
- Accepts a read request `{RD, SEL}` using the same 4-bit register encoding as the write path. Selects the addressed 8- or 16-bit register from the register-file output lanes and returns it through a buffered valid/ready response queue.
- Forwards same-cycle writes (`WE`/`WDATA`), so a read never returns stale data.
- Sits between the register file and the ALU/operand-fetch stage.

Parameters:
- DEPTH, 2, response queue entries (power of two, minimum 2).
- BYPASS_EN, 1, 1 = forward same-cycle writes into the read data; 0 = read the register file only.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  synchronous reset, active low.
- RD  input  1  read request.
- SEL  input  4  register select. 0..7 = AL,CL,DL,BL,AH,CH,DH,BH; 8..11 = AX,CX,DX,BX; 12..15 = SP,BP,SI,DI.
- RD_RDY  output  1  request accepted this cycle when RD && RD_RDY.
- RF_BYTE  input  64  byte lanes. [7:0]=AL, [15:8]=CL, [23:16]=DL, [31:24]=BL, [39:32]=AH, [47:40]=CH, [55:48]=DH, [63:56]=BH.
- RF_WORD  input  64  word lanes. [15:0]=SP, [31:16]=BP, [47:32]=SI, [63:48]=DI.
- WE  input  12  write enables, one hot per lane. Bit 11..0 = AL,CL,DL,BL,AH,CH,DH,BH,SP,BP,SI,DI.
- WDATA  input  16  write data of the current cycle.
- DOUT  output  16  response data; byte reads are zero-extended.
- DWORD  output  1  1 = response came from a 16-bit select (SEL >= 8).
- DVALID  output  1  response valid.
- DREADY  input  1  consumer accepts the response when DVALID && DREADY.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - Queue empties; DVALID=0, DOUT=0, DWORD=0.
  - RD_RDY=1 from the first cycle after reset.
  - Requests presented during reset are dropped. An in-flight response is discarded.
- Acceptance:
  - A request is pushed when RD && RD_RDY.
  - RD_RDY = (count < DEPTH), registered from count; it does not depend on DREADY combinationally.
  - A request issued while RD_RDY=0 is ignored; the requester must hold it.
- Data selection at acceptance (combinational, captured in the same edge):
  - SEL 0..7: byte lane SEL.
  - SEL 8..11: {high lane SEL-4, low lane SEL-8}.
  - SEL 12..15: word lane SEL-12.
- Bypass (BYPASS_EN=1): a lane with WE set in the accept cycle takes the forwarded value instead of the RF value.
  - Low-byte lanes (AL..BL) take WDATA[7:0].
  - High-byte lanes (AH..BH) take WDATA[15:8] if the paired low lane is also set (16-bit write), else WDATA[7:0].
  - Word lanes take WDATA.
  - Lanes are forwarded independently.
- Latency: accept at edge N → DVALID=1 with data after edge N when the queue was empty (1 cycle).
- Queue behaviour:
  - Strict FIFO ordering.
  - Queue states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
  - Pop in FULL raises RD_RDY on the next cycle.
- Output stability: DOUT/DWORD are held stable while DVALID && !DREADY.
- Illegal-condition guard: WE multi-hot with non-pair patterns is still forwarded per lane; no error is flagged.

Decomposition:
- Package `reg_read_pkg`:
  - SEL encodings (SEL_AL..SEL_DI).
  - WE bit indices.
  - Lane-width constants.
  - Byte/word lane index functions.
- Sub-module `reg_read_fifo` (parameter DEPTH, 17-bit entries {DWORD, DOUT}):
  - Holds the pointers, count, RD_RDY and the valid/ready output.
  - The top level keeps only the select/bypass mux.

Test Plan:
- Reset, then RD=1, SEL=4'h0, RF_BYTE[7:0]=8'h5A, DREADY=1 → next cycle DVALID=1, DOUT=16'h005A, DWORD=0.
- SEL=4'h8, AL=8'h34, AH=8'h12, same-cycle WE=12'b100010000000, WDATA=16'hBEEF → DOUT=16'hBEEF, DWORD=1.
- SEL=4'h4 (AH), WE=12'b000010000000 only, WDATA=16'h00C3 → DOUT=16'h00C3. Repeat with BYPASS_EN=0 → DOUT = RF AH value.
- DREADY=0, three back-to-back reads SEL=C,D,E with SP=1111, BP=2222, SI=3333:
  - RD_RDY drops after two accepts; the third request is held.
  - Raise DREADY → responses 1111, 2222, 3333 in order; DOUT held stable during the stall.
- Queue FULL with DREADY=1 and RD=1 held → one pop and one push per cycle after recovery; no loss or duplication over 20 reads.
- Assert RST_N=0 with 2 responses queued → DVALID=0 and DOUT=0 next cycle; the queued data is never presented.
